// File: rtl/cell_array_seq.sv
// Command sequencer for the in-memory compute row array: turns one ALU/LOAD/READ
// command at a time into registered one-hot array controls and returns one response.
module cell_array_seq #(
  parameter int COLS = 32,
  parameter int ROWS = 32,
  parameter int AW   = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [AW-1:0]   cmd_src_a,
  input  logic [AW-1:0]   cmd_src_b,
  input  logic [AW-1:0]   cmd_dst,
  input  logic            cmd_carry,
  input  logic [COLS-1:0] cmd_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [COLS-1:0] rsp_data,
  output logic            rsp_ovf,
  output logic            rsp_err,
  output logic [ROWS-1:0] arr_rd_addr_up,
  output logic [ROWS-1:0] arr_rd_addr_dn,
  output logic [ROWS-1:0] arr_wr_addr_up,
  output logic [ROWS-1:0] arr_wr_addr_dn,
  output logic [ROWS-1:0] arr_wr_en,
  output logic [3:0]      arr_op_fa,
  output logic            arr_carry_in,
  output logic [COLS-1:0] arr_data_in_up,
  input  logic [COLS-1:0] arr_rd_out_up,
  input  logic [ROWS-1:0] arr_overflow
);

  typedef enum logic [1:0] {S_IDLE, S_SRC, S_WB, S_RESP} state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd4;
  localparam logic [2:0] OP_READ = 3'd5;

  function automatic logic [ROWS-1:0] onehot(input logic [AW-1:0] idx);
    return {{(ROWS-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic in_rng(input logic [AW-1:0] idx);
    return ({1'b0, idx} < (AW+1)'(ROWS));
  endfunction

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [AW-1:0]   src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic            carry_q, carry_d;
  logic [COLS-1:0] data_q, data_d;
  logic [COLS-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_ovf_q, rsp_ovf_d, rsp_err_q, rsp_err_d;
  logic [ROWS-1:0] rd_up_q, rd_up_d, rd_dn_q, rd_dn_d, wr_q, wr_d;
  logic [3:0]      op_fa_q, op_fa_d;
  logic            carry_in_q, carry_in_d;
  logic [COLS-1:0] data_in_q, data_in_d;

  logic cmd_fire, cmd_alu, cmd_load, cmd_read, cmd_err, alu_q;

  assign cmd_fire = cmd_valid && (state_q == S_IDLE);
  assign cmd_alu  = ~cmd_op[2];
  assign cmd_load = (cmd_op == OP_LOAD);
  assign cmd_read = (cmd_op == OP_READ);
  assign cmd_err  = (cmd_op[2:1] == 2'b11)
                  || (cmd_alu && !(in_rng(cmd_src_a) && in_rng(cmd_src_b) && in_rng(cmd_dst)))
                  || (cmd_load && !in_rng(cmd_dst))
                  || (cmd_read && !in_rng(cmd_src_a));
  assign alu_q    = ~op_q[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dst_q      <= '0;
      carry_q    <= 1'b0;
      data_q     <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
      rd_up_q    <= '0;
      rd_dn_q    <= '0;
      wr_q       <= '0;
      op_fa_q    <= '0;
      carry_in_q <= 1'b0;
      data_in_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      src_a_q    <= src_a_d;
      src_b_q    <= src_b_d;
      dst_q      <= dst_d;
      carry_q    <= carry_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_err_q  <= rsp_err_d;
      rd_up_q    <= rd_up_d;
      rd_dn_q    <= rd_dn_d;
      wr_q       <= wr_d;
      op_fa_q    <= op_fa_d;
      carry_in_q <= carry_in_d;
      data_in_q  <= data_in_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_fire) state_d = cmd_err ? S_RESP : (cmd_load ? S_WB : S_SRC);
      S_SRC:  state_d = alu_q ? S_WB : S_RESP;
      S_WB:   state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_d    = cmd_fire ? cmd_op    : op_q;
    src_a_d = cmd_fire ? cmd_src_a : src_a_q;
    src_b_d = cmd_fire ? cmd_src_b : src_b_q;
    dst_d   = cmd_fire ? cmd_dst   : dst_q;
    carry_d = cmd_fire ? cmd_carry : carry_q;
    data_d  = cmd_fire ? cmd_data  : data_q;
  end

  // Array controls are computed one cycle ahead so they appear registered in SRC/WB.
  always_comb begin
    rsp_data_d = rsp_data_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_err_d  = rsp_err_q;
    rd_up_d    = '0;
    rd_dn_d    = '0;
    wr_d       = '0;
    op_fa_d    = '0;
    carry_in_d = 1'b0;
    data_in_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          rsp_data_d = '0;
          rsp_ovf_d  = 1'b0;
          rsp_err_d  = cmd_err;
          if (!cmd_err) begin
            if (cmd_load) begin
              wr_d      = onehot(cmd_dst);
              data_in_d = cmd_data;
            end else begin
              rd_up_d = onehot(cmd_src_a);
              if (cmd_alu) begin
                rd_dn_d    = onehot(cmd_src_b);
                op_fa_d    = 4'b0001 << cmd_op[1:0];
                carry_in_d = (cmd_op == OP_ADD) && cmd_carry;
              end
            end
          end
        end
      end
      S_SRC: begin
        if (alu_q) begin
          rd_up_d    = onehot(src_a_q);
          rd_dn_d    = onehot(src_b_q);
          op_fa_d    = 4'b0001 << op_q[1:0];
          carry_in_d = (op_q == OP_ADD) && carry_q;
          wr_d       = onehot(dst_q);
        end else begin
          rsp_data_d = arr_rd_out_up;
        end
      end
      S_WB: begin
        if (alu_q) rsp_data_d = arr_rd_out_up;
        rsp_ovf_d = (op_q == OP_ADD) && arr_overflow[dst_q];
      end
      default: ;
    endcase
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_data       = rsp_data_q;
  assign rsp_ovf        = rsp_ovf_q;
  assign rsp_err        = rsp_err_q;
  assign arr_rd_addr_up = rd_up_q;
  assign arr_rd_addr_dn = rd_dn_q;
  assign arr_wr_addr_up = wr_q;
  assign arr_wr_addr_dn = '0;
  assign arr_wr_en      = wr_q;
  assign arr_op_fa      = op_fa_q;
  assign arr_carry_in   = carry_in_q;
  assign arr_data_in_up = data_in_q;

endmodule

// File: tb/tb_cell_array_seq.sv
// Bench for cell_array_seq: behavioural row array on the DUT side, command-level
// reference rows for expectations, directed steps followed by random commands.
module tb_cell_array_seq;
  localparam int COLS = 32;
  localparam int ROWS = 20;
  localparam int AW   = $clog2(ROWS);

  logic            clk, rst;
  logic            cmd_valid, cmd_ready, cmd_carry;
  logic [2:0]      cmd_op;
  logic [AW-1:0]   cmd_src_a, cmd_src_b, cmd_dst;
  logic [COLS-1:0] cmd_data;
  logic            rsp_valid, rsp_ready, rsp_ovf, rsp_err;
  logic [COLS-1:0] rsp_data;
  logic [ROWS-1:0] arr_rd_addr_up, arr_rd_addr_dn, arr_wr_addr_up, arr_wr_addr_dn, arr_wr_en;
  logic [3:0]      arr_op_fa;
  logic            arr_carry_in;
  logic [COLS-1:0] arr_data_in_up, arr_rd_out_up;
  logic [ROWS-1:0] ovf_in;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] ref_rows [ROWS];

  cell_array_seq #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .cmd_carry(cmd_carry), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .arr_rd_addr_up(arr_rd_addr_up), .arr_rd_addr_dn(arr_rd_addr_dn),
    .arr_wr_addr_up(arr_wr_addr_up), .arr_wr_addr_dn(arr_wr_addr_dn),
    .arr_wr_en(arr_wr_en), .arr_op_fa(arr_op_fa), .arr_carry_in(arr_carry_in),
    .arr_data_in_up(arr_data_in_up), .arr_rd_out_up(arr_rd_out_up),
    .arr_overflow(ovf_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COLS-1:0] env_alu(input logic [COLS-1:0] a, input logic [COLS-1:0] b,
                                              input logic [3:0] fa, input logic c);
    case (fa)
      4'b0001: return a + b + COLS'(c);
      4'b0010: return a & b;
      4'b0100: return a ^ b;
      4'b1000: return a | b;
      default: return '0;
    endcase
  endfunction

  function automatic logic [COLS-1:0] ref_alu(input int op, input logic [COLS-1:0] a,
                                              input logic [COLS-1:0] b, input logic c);
    case (op)
      0: return a + b + COLS'(c);
      1: return a & b;
      2: return a ^ b;
      default: return a | b;
    endcase
  endfunction

  // Behavioural row array driven by the DUT's one-hot controls.
  always_comb begin
    logic [COLS-1:0] av, bv;
    av = '0;
    bv = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (arr_rd_addr_up[i]) av = mem[i];
      if (arr_rd_addr_dn[i]) bv = mem[i];
    end
    arr_rd_out_up = (arr_op_fa != 4'b0) ? env_alu(av, bv, arr_op_fa, arr_carry_in) : av;
  end

  always @(posedge clk) begin
    check("wr_en_onehot", $countones(arr_wr_en) <= 1, 1'b1);
    for (int i = 0; i < ROWS; i++)
      if (arr_wr_en[i]) mem[i] <= (arr_op_fa != 4'b0) ? arr_rd_out_up : arr_data_in_up;
    if (arr_wr_en != '0) wr_count++;
  end

  task automatic check_arr_idle(input string tag);
    check({tag, "_rd_up"}, arr_rd_addr_up, '0);
    check({tag, "_rd_dn"}, arr_rd_addr_dn, '0);
    check({tag, "_wr_en"}, arr_wr_en, '0);
    check({tag, "_wr_up"}, arr_wr_addr_up, '0);
    check({tag, "_op_fa"}, arr_op_fa, '0);
    check({tag, "_din"}, arr_data_in_up, '0);
  endtask

  task automatic do_cmd(input int op, input int a, input int b, input int d,
                        input logic c, input logic [COLS-1:0] data, input int stall);
    logic is_alu, is_load, is_read, err, wb, e_ovf;
    logic [COLS-1:0] e_data;
    logic [ROWS-1:0] oha, ohb, ohd;
    logic [3:0] e_fa;
    int lat, w0, extra;
    is_alu  = (op <= 3);
    is_load = (op == 4);
    is_read = (op == 5);
    err = (op > 5) || (is_alu && (a >= ROWS || b >= ROWS || d >= ROWS))
       || (is_load && d >= ROWS) || (is_read && a >= ROWS);
    oha = '0; ohb = '0; ohd = '0;
    if (a < ROWS) oha[a] = 1'b1;
    if (b < ROWS) ohb[b] = 1'b1;
    if (d < ROWS) ohd[d] = 1'b1;
    case (op)
      0: e_fa = 4'b0001;
      1: e_fa = 4'b0010;
      2: e_fa = 4'b0100;
      3: e_fa = 4'b1000;
      default: e_fa = 4'b0000;
    endcase
    ovf_in = ROWS'($urandom);
    e_data = '0;
    e_ovf  = 1'b0;
    if (!err && is_read) e_data = ref_rows[a];
    if (!err && is_alu) e_data = ref_alu(op, ref_rows[a], ref_rows[b], c);
    if (!err && op == 0) e_ovf = ovf_in[d];
    lat = err ? 1 : (is_alu ? 3 : 2);

    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_src_a = AW'(a);
    cmd_src_b = AW'(b);
    cmd_dst   = AW'(d);
    cmd_carry = c;
    cmd_data  = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_src_a = AW'($urandom);
    cmd_src_b = AW'($urandom);
    cmd_dst   = AW'($urandom);
    cmd_carry = 1'($urandom);
    cmd_data  = $urandom;
    w0 = wr_count;

    for (int k = 1; k < lat; k++) begin
      wb = (is_alu && k == 2) || (is_load && k == 1);
      check("busy_rsp_valid", rsp_valid, 1'b0);
      check("busy_cmd_ready", cmd_ready, 1'b0);
      check("ph_rd_up", arr_rd_addr_up, (is_alu || is_read) ? oha : '0);
      check("ph_rd_dn", arr_rd_addr_dn, is_alu ? ohb : '0);
      check("ph_wr_en", arr_wr_en, wb ? ohd : '0);
      check("ph_wr_up", arr_wr_addr_up, wb ? ohd : '0);
      check("ph_wr_dn", arr_wr_addr_dn, '0);
      check("ph_op_fa", arr_op_fa, e_fa);
      check("ph_carry", arr_carry_in, is_alu && op == 0 && c);
      check("ph_din", arr_data_in_up, is_load ? data : '0);
      @(posedge clk); #1;
    end

    check("rsp_latency", rsp_valid, 1'b1);
    extra = 0;
    while (!rsp_valid && extra < 8) begin
      @(posedge clk); #1;
      extra++;
    end
    ovf_in = ~ovf_in;
    check("rsp_data", rsp_data, e_data);
    check("rsp_ovf", rsp_ovf, e_ovf);
    check("rsp_err", rsp_err, err);
    check("rsp_cmd_ready", cmd_ready, 1'b0);
    check_arr_idle("resp");
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_data", rsp_data, e_data);
      check("stall_ovf", rsp_ovf, e_ovf);
      check("stall_err", rsp_err, err);
      check("stall_cmd_ready", cmd_ready, 1'b0);
      check_arr_idle("stall");
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 1'b0);
    check("post_cmd_ready", cmd_ready, 1'b1);
    check("write_count", wr_count - w0, (!err && !is_read) ? 1 : 0);
    if (!err && is_load) ref_rows[d] = data;
    if (!err && is_alu) ref_rows[d] = e_data;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, op, a, b, d;
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_src_a = '0; cmd_src_b = '0; cmd_dst = '0;
    cmd_carry = 1'b0; cmd_data = '0; rsp_ready = 1'b0; ovf_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_ovf", rsp_ovf, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_carry", arr_carry_in, 1'b0);
    check_arr_idle("rst");
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < ROWS; i++) do_cmd(4, 0, 0, i, 1'b0, $urandom, 0);

    do_cmd(4, 0, 0, 3, 1'b0, 32'h0000_00FF, 0);
    do_cmd(5, 3, 0, 0, 1'b0, '0, 0);
    do_cmd(4, 0, 0, 3, 1'b0, 32'hFFFF_FFFF, 0);
    do_cmd(4, 0, 0, 4, 1'b0, 32'h0000_0001, 0);
    do_cmd(0, 3, 4, 5, 1'b0, '0, 0);
    do_cmd(5, 5, 0, 0, 1'b0, '0, 0);
    do_cmd(0, 3, 3, 3, 1'b1, '0, 1);
    do_cmd(6, 1, 2, 3, 1'b0, '0, 0);
    do_cmd(7, 1, 2, 3, 1'b0, '0, 0);
    do_cmd(4, 0, 0, ROWS, 1'b0, 32'h1234_5678, 0);
    do_cmd(5, ROWS + 3, 0, 0, 1'b0, '0, 0);
    do_cmd(1, 1, ROWS, 2, 1'b0, '0, 0);
    do_cmd(2, 6, 7, 8, 1'b0, '0, 5);

    // Reset during the WB cycle of a LOAD must abandon the write.
    w0 = wr_count;
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_dst = AW'(7); cmd_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("wb_wr_en_before_rst", arr_wr_en, ROWS'(1) << 7);
    #3;
    rst = 1'b0;
    #1;
    check("rst_async_wr_en", arr_wr_en, '0);
    check("rst_async_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_no_write", wr_count - w0, 0);
    check("rst_release_cmd_ready", cmd_ready, 1'b1);
    check("rst_release_rsp_valid", rsp_valid, 1'b0);
    do_cmd(5, 7, 0, 0, 1'b0, '0, 0);
    do_cmd(4, 0, 0, 7, 1'b0, 32'hCAFE_F00D, 0);
    do_cmd(5, 7, 0, 0, 1'b0, '0, 0);

    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 6);
      a  = ($urandom_range(0, 15) == 0) ? ROWS : $urandom_range(0, ROWS - 1);
      b  = ($urandom_range(0, 15) == 0) ? ROWS : $urandom_range(0, ROWS - 1);
      d  = ($urandom_range(0, 15) == 0) ? ROWS : $urandom_range(0, ROWS - 1);
      do_cmd(op, a, b, d, 1'($urandom), $urandom, $urandom_range(0, 2));
    end

    for (int i = 0; i < ROWS; i++) do_cmd(5, i, 0, 0, 1'b0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cell_array_seq.md
# cell_array_seq

Command sequencer for the in-memory compute row array. Accepts one command at a time over a valid/ready port: row-to-row ALU op, load row, or read row. Translates each command into the one-hot row selects, write enables, full-adder op select and carry for the array. Returns one response per command (data, overflow, error) over a second valid/ready port.

## Interface
Parameters:
- COLS, 32, bits per row (array data width)
- ROWS, 32, rows in the array; ROWS >= 3
- AW, $clog2(ROWS), row index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept; high only in IDLE
- cmd_op  in  3  0 ADD, 1 AND, 2 XOR, 3 OR, 4 LOAD, 5 READ, 6/7 illegal
- cmd_src_a  in  AW  row driven on the up read bus (ALU op, READ)
- cmd_src_b  in  AW  row driven on the down read bus (ALU op only)
- cmd_dst  in  AW  destination row (ALU op, LOAD)
- cmd_carry  in  1  carry-in for ADD; ignored otherwise
- cmd_data  in  COLS  LOAD data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_data  out  COLS  READ: row contents; ALU: rd_out_up sampled in WB; LOAD/error: 0
- rsp_ovf  out  1  overflow[dst] after ADD; 0 otherwise
- rsp_err  out  1  illegal op or any used index >= ROWS
- arr_rd_addr_up, arr_rd_addr_dn  out  ROWS  one-hot read selects
- arr_wr_addr_up, arr_wr_addr_dn  out  ROWS  one-hot write selects (dn always 0)
- arr_wr_en  out  ROWS  one-hot row write enable
- arr_op_fa  out  4  one-hot: ADD 0001, AND 0010, XOR 0100, OR 1000
- arr_carry_in  out  1  carry to row 0 of the adder chain
- arr_data_in_up  out  COLS  LOAD data; 0 otherwise
- arr_rd_out_up  in  COLS  array up read output
- arr_overflow  in  ROWS  per-row overflow flags

## Operation
- States: IDLE, SRC, WB, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* fields into registers and decode:
  - illegal op or bad index: go to RESP with rsp_err=1, no array control asserted.
  - LOAD: go to WB.
  - READ: go to SRC.
  - ALU: go to SRC.
- SRC (1 cycle):
  - arr_rd_addr_up = onehot(src_a).
  - ALU: also drive arr_rd_addr_dn = onehot(src_b), arr_op_fa, and arr_carry_in (ADD: latched carry; else 0).
  - READ: capture arr_rd_out_up into rsp_data at end of cycle, then go to RESP.
  - ALU: go to WB.
- WB (1 cycle):
  - ALU: keep SRC drives; add arr_wr_addr_up = arr_wr_en = onehot(dst). Capture arr_rd_out_up into rsp_data.
  - LOAD: arr_data_in_up = latched data; arr_wr_addr_up = arr_wr_en = onehot(dst); op_fa = 0.
  - Go to RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable.
  - rsp_ovf = arr_overflow[dst], sampled on entry to RESP, for ADD only.
  - On rsp_ready, go to IDLE.
- All array outputs are registered. They are 0 in IDLE and RESP and whenever not listed above.
- src_a == src_b, dst == src_a, and dst == src_b are all legal. The written value comes from the pre-edge row contents.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, cmd_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_ovf=0, rsp_err=0, all arr_* outputs=0. Reset in SRC/WB abandons the write immediately; no partial write is issued after release.
- Command accepted at edge T (cmd_valid & cmd_ready):
  - ALU: SRC in cycle T+1, WB in T+2, rsp_valid from T+3.
  - READ: SRC in T+1, rsp_valid from T+2.
  - LOAD: WB in T+1, rsp_valid from T+2.
  - Error: rsp_valid from T+1.
- Back-to-back: next command is accepted at earliest 1 cycle after the rsp handshake edge; no overlap.
- rsp_valid is held with stable data until rsp_ready. Stalling does not re-issue any array access.

## Test plan
- LOAD dst=3 data=0x0000_00FF, then READ src_a=3 -> rsp_data=0x0000_00FF, rsp_err=0, rsp_valid 2 cycles after each accept.
- ADD src_a=3 (0xFFFFFFFF), src_b=4 (0x1), carry=0, dst=5 -> arr_op_fa=0001 in SRC and WB, arr_wr_en=1<<5 only in WB, rsp_ovf=arr_overflow[5], rsp_valid at T+3.
- cmd_op=6 or cmd_dst=ROWS (when ROWS is not a power of two) -> rsp_err=1, rsp_data=0, no arr_wr_en/arr_rd_addr pulse, rsp_valid at T+1.
- Hold rsp_ready=0 for 5 cycles after an XOR -> rsp_* stable, cmd_ready=0, all arr_* = 0 throughout, single write observed.
- Assert rst=0 mid-cycle during WB -> arr_wr_en drops to 0 asynchronously, rsp_valid=0; after release, cmd_ready=1 and the next LOAD completes normally.
- Random back-to-back commands against a reference row model -> every response matches; arr_wr_en is never more than one-hot.
